// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and instruction fetch front end
// Purpose: owns the PC and fetches instructions from memory over a req/ack
//   handshake. It applies flush and branch redirects, drops fetches made stale
//   by a redirect, and feeds the IF/ID register while honouring stall.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   flush_i, new_pc_i                exception flush and vector (beats branch)
//   branch_flag_i, branch_target_i   taken branch resolved in ID
//   stall_i                          IF/ID must hold its contents
//   inst_req_o, inst_addr_o          fetch request, stable until acked
//   inst_ack_i, inst_rdata_i         memory completion and instruction word
//   pc_o, instr_o, instr_valid_o     instruction presented to IF/ID
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        stall_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_ack_i,
  input  logic [31:0] inst_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        instr_valid_o
);

  typedef enum logic [1:0] {S_BOOT, S_REQ, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  // Address of the next request to start; while stale_q is set it holds the
  // pending redirect target.
  logic [31:0] next_pc_q, next_pc_d;
  logic        stale_q, stale_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  // One-entry skid slot: catches the in-flight ack when stall rises while the
  // output register is already full, so that fetch is never lost or repeated.
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;

  logic        redirect;
  logic [31:0] target;
  logic        ack;
  logic        good_ack;
  logic [31:0] fetch_pc;
  logic        can_start;
  logic        start;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and handshake decisions
  always_comb begin
    redirect = flush_i | branch_flag_i;
    target   = flush_i ? new_pc_i : branch_target_i;
    ack      = (state_q == S_REQ) && inst_ack_i;
    // Data is usable only if it is not stale and no redirect lands with it.
    good_ack = ack && !stale_q && !redirect;

    if (redirect) begin
      fetch_pc = target;
    end else if (ack && !stale_q) begin
      fetch_pc = addr_q + PC_INC;
    end else begin
      fetch_pc = next_pc_q;
    end

    valid_d     = valid_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    buf_valid_d = buf_valid_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    if (redirect) begin
      // Anything already fetched is wrong-path; this overrides stall.
      valid_d     = 1'b0;
      buf_valid_d = 1'b0;
    end else if (stall_i && valid_q) begin
      if (good_ack) begin
        buf_valid_d = 1'b1;
        buf_pc_d    = addr_q;
        buf_instr_d = inst_rdata_i;
      end
    end else if (buf_valid_q) begin
      // No request is ever outstanding while the skid slot is full.
      valid_d     = 1'b1;
      pc_d        = buf_pc_q;
      instr_d     = buf_instr_q;
      buf_valid_d = 1'b0;
    end else if (good_ack) begin
      valid_d = 1'b1;
      pc_d    = addr_q;
      instr_d = inst_rdata_i;
    end else begin
      valid_d = 1'b0;
    end

    // Only start a request whose data is guaranteed a landing slot even if
    // stall persists.
    can_start = !stall_i || (!valid_d && !buf_valid_d);
    start     = can_start && ((state_q != S_REQ) || ack);

    addr_d    = start ? fetch_pc : addr_q;
    next_pc_d = fetch_pc;
    stale_d   = stale_q;
    if (ack) begin
      stale_d = 1'b0;
    end else if ((state_q == S_REQ) && redirect) begin
      stale_d = 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT, S_HOLD: state_d = start ? S_REQ : S_HOLD;
      S_REQ: begin
        if (ack) begin
          state_d = start ? S_REQ : S_HOLD;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  // Outputs
  always_comb begin
    inst_req_o    = (state_q == S_REQ);
    inst_addr_o   = addr_q;
    pc_o          = pc_q;
    instr_o       = instr_q;
    instr_valid_o = valid_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= RESET_PC;
      next_pc_q   <= RESET_PC;
      stale_q     <= 1'b0;
      pc_q        <= 32'h0;
      instr_q     <= 32'h0;
      valid_q     <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= 32'h0;
      buf_instr_q <= 32'h0;
    end else begin
      addr_q      <= addr_d;
      next_pc_q   <= next_pc_d;
      stale_q     <= stale_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      buf_valid_q <= buf_valid_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
    end
  end

endmodule
